// File: rtl/gcd_avalon_driver.sv
// Sequences one GCD operation on an Avalon-MM GCD slave: write operands, wait for idle, start, poll, read result.
// Define GCD_DRV_CYCLES_EN to report the slave's cycle count on res_cyc; otherwise res_cyc is tied to zero.
module gcd_avalon_driver #(
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_gcd,
  output logic [15:0] res_cyc,
  output logic        res_err,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, PRECHK, WR_GO, SETTLE, POLL, RD_R, RESP
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   a_reg, b_reg, gcd_reg;
  logic [CW-1:0] poll_cnt_reg;
  logic          err_reg;
  logic          init_reg;
  logic          slave_ready;
  logic          polling;
  logic          timeout_hit;

  assign slave_ready = m_readdata[31];
  assign polling     = (state_reg == PRECHK) || (state_reg == POLL);
  assign timeout_hit = polling && !slave_ready && (poll_cnt_reg == POLL_LAST);

  // init_reg keeps op_ready low while reset is held and for the first edge after release
  assign op_ready  = (state_reg == IDLE) && init_reg;
  assign res_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign res_gcd   = gcd_reg;
  assign res_err   = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (op_valid && op_ready) state_next = WR_A;
      WR_A:   state_next = WR_B;
      WR_B:   state_next = PRECHK;
      PRECHK: begin
        if (slave_ready)      state_next = WR_GO;
        else if (timeout_hit) state_next = RESP;
      end
      WR_GO:  state_next = SETTLE;
      SETTLE: state_next = POLL;
      POLL: begin
        if (slave_ready)      state_next = RD_R;
        else if (timeout_hit) state_next = RESP;
      end
      RD_R:   state_next = RESP;
      RESP:   if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus strobes depend on the state register alone so they never glitch with readdata
  always_comb begin
    m_address    = 3'd0;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_read       = 1'b0;
    m_writedata  = 32'd0;
    case (state_reg)
      WR_A: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_writedata  = a_reg;
      end
      WR_B: begin
        m_address    = 3'd1;
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_writedata  = b_reg;
      end
      WR_GO: begin
        m_address    = 3'd2;
        m_chipselect = 1'b1;
        m_write      = 1'b1;
      end
      PRECHK, POLL: begin
        m_address    = 3'd3;
        m_chipselect = 1'b1;
        m_read       = 1'b1;
      end
      RD_R: begin
        m_address    = 3'd4;
        m_chipselect = 1'b1;
        m_read       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_reg     <= 1'b0;
      a_reg        <= 32'd0;
      b_reg        <= 32'd0;
      gcd_reg      <= 32'd0;
      err_reg      <= 1'b0;
      poll_cnt_reg <= '0;
    end else begin
      init_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (op_valid && op_ready) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            err_reg <= 1'b0;
          end
        end
        WR_B, WR_GO: poll_cnt_reg <= '0;
        PRECHK, POLL: begin
          if (!slave_ready) poll_cnt_reg <= poll_cnt_reg + 1'b1;
          if (timeout_hit) begin
            err_reg <= 1'b1;
            gcd_reg <= 32'd0;
          end
        end
        RD_R: gcd_reg <= m_readdata;
        default: ;
      endcase
    end
  end

`ifdef GCD_DRV_CYCLES_EN
  logic [15:0] cyc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_reg <= 16'd0;
    end else if (timeout_hit) begin
      cyc_reg <= 16'd0;
    end else if (state_reg == POLL && slave_ready) begin
      cyc_reg <= m_readdata[15:0];
    end
  end

  assign res_cyc = cyc_reg;
`else
  assign res_cyc = 16'd0;
`endif

endmodule

// File: tb/tb_gcd_avalon_driver.sv
// Randomized self-checking bench for gcd_avalon_driver with a behavioural Avalon GCD slave.
// Expected results come from plain Euclid arithmetic and the latency rules of the driver.
module tb_gcd_avalon_driver;

  localparam int TMO = 16;
  localparam logic [4:0] W0 = 5'h18, W1 = 5'h19, W2 = 5'h1A, R3 = 5'h13, R4 = 5'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_gcd;
  logic [15:0] res_cyc;
  logic        res_err;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write, m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        busy;

  int total = 0;
  int bad = 0;
  int viol = 0;
  logic [4:0] trace[$];

  gcd_avalon_driver #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd),
    .res_cyc(res_cyc), .res_err(res_err),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_read(m_read), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // behavioural slave: ready drops the cycle after start and returns sl_dly cycles later
  logic [31:0] sl_a = 0, sl_b = 0, sl_res = 0;
  logic [15:0] sl_cyc = 0;
  int          sl_cnt = 0;
  int          sl_dly = 1;
  bit          sl_stuck = 0;
  bit          sl_clear = 0;
  logic        sl_ready;

  assign sl_ready = (sl_cnt == 0) && !sl_stuck;

  always @(posedge clk) begin
    if (m_chipselect && m_write && m_address == 3'd0) sl_a <= m_writedata;
    if (m_chipselect && m_write && m_address == 3'd1) sl_b <= m_writedata;
    if (m_chipselect && m_write && m_address == 3'd2) begin
      sl_res <= gcd_ref(sl_a, sl_b);
      sl_cyc <= 16'(sl_dly * 2 + 3);
      sl_cnt <= sl_dly;
    end else if (sl_clear) begin
      sl_cnt <= 0;
    end else if (sl_cnt > 0) begin
      sl_cnt <= sl_cnt - 1;
    end
  end

  always_comb begin
    m_readdata = 32'd0;
    if (m_address == 3'd3) m_readdata = {sl_ready, 15'd0, sl_cyc};
    else if (m_address == 3'd4) m_readdata = sl_res;
  end

  always @(negedge clk) begin
    if (busy) trace.push_back(m_chipselect ? {1'b1, m_write, m_address} : 5'd0);
    if (!busy && (m_chipselect || m_write || m_read)) viol++;
    if (busy && op_ready) viol++;
    if (res_valid && m_chipselect) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int dly,
                       input int rr_wait, input bit hold_valid,
                       output int lat, output int pre_n, output int poll_n);
    logic [31:0] exp_gcd;
    logic [15:0] exp_cyc;
    bit          exp_err;
    int          exp_start, n_w0, n_w2, i2, li;
    exp_err   = sl_stuck || (dly > TMO);
    exp_start = sl_stuck ? 0 : 1;
    exp_gcd   = exp_err ? 32'd0 : gcd_ref(a, b);
`ifdef GCD_DRV_CYCLES_EN
    exp_cyc   = exp_err ? 16'd0 : 16'(dly * 2 + 3);
`else
    exp_cyc   = 16'd0;
`endif
    sl_dly = dly;
    for (int i = 0; i < 40 && !op_ready; i++) @(negedge clk);
    check("op_ready_wait", {31'd0, op_ready}, 32'd1);
    @(posedge clk); #1;
    trace.delete();
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    res_ready = (rr_wait == 0);
    @(posedge clk); #1;
    if (!hold_valid) op_valid = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
    end
    op_valid = 1'b0;
    check("res_valid_seen", {31'd0, res_valid}, 32'd1);
    check("res_gcd", res_gcd, exp_gcd);
    check("res_err", {31'd0, res_err}, {31'd0, exp_err});
    check("res_cyc", {16'd0, res_cyc}, {16'd0, exp_cyc});
    for (int i = 0; i < rr_wait; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_gcd", res_gcd, exp_gcd);
    end
    if (rr_wait > 0) begin
      @(posedge clk); #1;
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("idle_after_resp", {30'd0, res_valid, busy}, 32'd0);

    n_w0 = 0; n_w2 = 0; i2 = -1; li = -1; pre_n = 0; poll_n = 0;
    foreach (trace[i]) begin
      if (trace[i] == W0) n_w0++;
      if (trace[i] == W2) begin
        n_w2++;
        if (i2 < 0) i2 = i;
      end
      if (trace[i] == R3) begin
        if (i2 < 0) pre_n++;
        else poll_n++;
      end
      if (trace[i] != 5'd0) li = i;
    end
    check("n_write_a", n_w0, 1);
    check("n_start", n_w2, exp_start);
    if (trace.size() >= 3) begin
      check("seq_0_1_3", {trace[0], trace[1], trace[2]}, {W0, W1, R3});
    end else begin
      check("trace_len", trace.size(), 3);
    end
    if (i2 >= 0 && i2 + 2 < trace.size()) begin
      check("settle_idle", {trace[i2 + 1], trace[i2 + 2]}, {5'd0, R3});
    end
    if (!exp_err && li >= 0) check("last_rd_result", {27'd0, trace[li]}, {27'd0, R4});
    $display("op a=%0h b=%0h dly=%0d gcd=%0h err=%0d cyc=%0d lat=%0d prechk=%0d polls=%0d",
             a, b, dly, res_gcd, res_err, res_cyc, lat, pre_n, poll_n);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, pre_n, poll_n;
    logic [31:0] g, ra, rb;
    int dly, rr;

    #23;
    check("rst_outputs", {op_ready, res_valid, res_err, busy, m_chipselect, m_write, m_read},
          32'd0);
    check("rst_gcd", res_gcd, 32'd0);
    check("rst_cyc", {16'd0, res_cyc}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, op_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {31'd0, op_ready}, 32'd1);

    do_op(32'd48, 32'd18, 1, 0, 0, lat, pre_n, poll_n);
    check("min_latency", lat, 8);
    do_op(32'hFFFFFFFF, 32'd1, 3, 2, 0, lat, pre_n, poll_n);
    check("lat_dly3", lat, 10);
    do_op(32'd100, 32'd75, 1, 0, 1, lat, pre_n, poll_n);
    check("hold_valid_lat", lat, 8);
    do_op(32'd35, 32'd14, 2, 5, 0, lat, pre_n, poll_n);
    do_op(32'd0, 32'd0, 1, 0, 0, lat, pre_n, poll_n);
    do_op(32'd0, 32'd12, 1, 1, 0, lat, pre_n, poll_n);

    // last poll before the limit still succeeds; one cycle slower times out
    do_op(32'd81, 32'd27, TMO, 0, 0, lat, pre_n, poll_n);
    check("lat_edge_ok", lat, 7 + TMO);
    check("polls_edge_ok", poll_n, TMO);
    do_op(32'd81, 32'd27, TMO + 1, 1, 0, lat, pre_n, poll_n);
    check("lat_poll_tmo", lat, 22);
    check("polls_tmo", poll_n, TMO);
    sl_clear = 1; @(negedge clk); sl_clear = 0;

    sl_stuck = 1;
    do_op(32'd9, 32'd6, 1, 0, 0, lat, pre_n, poll_n);
    check("lat_prechk_tmo", lat, 19);
    check("prechk_tmo_polls", pre_n, TMO);
    sl_stuck = 0;

    // reset while polling a slow slave; the next op must wait in PRECHK
    sl_dly = 20;
    @(posedge clk); #1;
    op_a = 32'd1000; op_b = 32'd10; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("in_poll", {28'd0, m_read, m_address}, {28'd0, 1'b1, 3'd3});
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_bus", {m_chipselect, m_write, m_read, busy, op_ready, res_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_ready_low", {31'd0, op_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_ready_high", {31'd0, op_ready}, 32'd1);
    do_op(32'd35, 32'd21, 1, 0, 0, lat, pre_n, poll_n);
    check("prechk_waited", {31'd0, pre_n > 1}, 32'd1);

    for (int n = 0; n < 20; n++) begin
      g   = $urandom_range(1, 1000);
      ra  = g * $urandom_range(0, 5000);
      rb  = g * $urandom_range(1, 5000);
      dly = $urandom_range(1, 18);
      rr  = $urandom_range(0, 3);
      do_op(ra, rb, dly, rr, 0, lat, pre_n, poll_n);
      if (dly > TMO) begin
        check("rnd_lat_tmo", lat, 22);
        sl_clear = 1; @(negedge clk); sl_clear = 0;
      end else begin
        check("rnd_lat", lat, 7 + dly);
      end
    end

    check("bus_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
